stage_sequencer: RTL and testbench
==================================

Name: stage_sequencer

Overview:
- Parametrised successor to the CPU's fixed 3-stage instruction scheduler control: sequences an instruction through up to NSTAGES configurable stages.
- Per stage, it optionally issues one TX command and optionally waits for RX data.
- It counts bit-serial ALU cycles itself (narrow or wide), repeats one selectable stage N times, and evaluates condition codes to skip instructions.
- Sits between the decoder (inst_valid/inst_done handshake) and the ALU/TX/RX datapath, driving the ALU advance enable and stage index.

Parameters:
NSTAGES, 4, number of stage slots (>=2)
REG_BITS, 8, register width in bits
NSHIFT, 2, bits processed per ALU cycle
REP_BITS, 4, width of repeat counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
inst_valid  in  1  instruction present; all instruction inputs stable until inst_done
inst_done  out  1  single-cycle pulse, instruction finished or skipped
stage_mask  in  NSTAGES  stages to execute, ascending index order
stage_send  in  NSTAGES  stage issues one TX command
stage_wait_rx  in  NSTAGES  stage consumes RX data; advance gated by rx_data_valid
stage_wide  in  NSTAGES  stage op is 2*REG_BITS bits (else REG_BITS)
repeat_stage  in  $clog2(NSTAGES)  index of repeatable stage
repeat_count  in  REP_BITS  executions of repeat_stage (0 = skip that stage)
use_cc  in  1  instruction is conditional
cc  in  4  condition code
flags  in  4  {c,v,s,z}
tx_command_valid  out  1  request TX command start
tx_command_started  in  1  TX accepted command (honoured only while tx_command_valid)
rx_data_valid  in  1  RX data bits present this cycle
busy  out  1  in RUN state
stage  out  $clog2(NSTAGES)  current stage index
rep_index  out  REP_BITS  current repetition of repeat_stage
counter  out  $clog2(2*REG_BITS/NSHIFT)  bit-serial cycle position within op
advance  out  1  ALU advances this cycle
op_last  out  1  advance && counter at final cycle of current op

Behaviour:
- Reset: state IDLE; stage=0, rep_index=0, counter=0, cmd_sent=0. All outputs 0. Reset mid-instruction aborts it; no inst_done is produced.
- Effective mask: em = stage_mask, with bit repeat_stage cleared when repeat_count==0.
- cc_ok:
  - cc[2:0]==000: always true; cc[3] ignored.
  - Else if cc[2]==0: cond = cc[1] ? s : z.
  - Else: cv = cc[0] ? v : c; cond = cc[1] ? (cv && !z) : cv.
  - Then cc_ok = cond ^ cc[3].
- IDLE with inst_valid:
  - If (use_cc && !cc_ok) || em==0: inst_done=1 combinationally in that cycle; stay IDLE.
  - Else go to RUN at the lowest set bit of em, with counter=0, rep_index=0, cmd_sent=0.
  - Flags are sampled only in this cycle. One cycle of entry latency.
- RUN, current stage s:
  - tx_command_valid = stage_send[s] && !cmd_sent.
  - cmd_sent <= 1 on tx_command_valid && tx_command_started.
  - advance = !(stage_send[s] && !cmd_sent) && !(stage_wait_rx[s] && !rx_data_valid). No advance in the cycle the command is started.
  - Each advance increments counter. Op length L = (stage_wide[s] ? 2*REG_BITS : REG_BITS)/NSHIFT.
  - op_last = advance && counter==L-1.
- On op_last:
  - If s==repeat_stage && rep_index+1 < repeat_count: rep_index++, counter=0, stay in s. cmd_sent is kept, so no resend.
  - Else, if a higher set bit exists in em: go to it, with counter=0, rep_index=0, cmd_sent=0.
  - Else: inst_done=1 in the same cycle; next state IDLE.
- After inst_done, the next cycle is IDLE. If inst_valid is still high there, it is treated as a new instruction.
- rx_data_valid is ignored in stages without stage_wait_rx. tx_command_started is ignored when tx_command_valid=0.
- Counter wraps only through op_last reset; it never exceeds L-1.
- busy=1 exactly while in RUN. stage, counter and rep_index hold their values while advance=0.

Test Plan:
- Mask=0001, no send/wait, narrow, REG_BITS=8/NSHIFT=2 -> busy 1 cycle after inst_valid; advance 4 cycles (counter 0..3); inst_done with op_last at cycle 5.
- Mask=0011, stage0 send+wide, stage1 wait_rx; started at cycle 3; rx_data_valid toggling -> stage0: 8 advances beginning after the start cycle. Stage1 advances only on rx_data_valid cycles, exactly 4 total. tx_command_valid drops after the start.
- use_cc=1, cc=4'b0001 (z), flags z=0 -> inst_done in the first cycle, busy never 1, tx_command_valid never 1. cc=4'b1001 with z=0 -> executes.
- cc=4'b0110 (c&&!z) with c=1, z=1 -> skipped. With c=1, z=0 -> executes.
- Mask=0110, repeat_stage=2, repeat_count=3, stage2 send -> stage2 runs 3×4 cycles with rep_index 0,1,2 and one TX command. repeat_count=0 -> only stage1 runs.
- Reset asserted mid stage1 with counter=2 -> next cycle all outputs 0, no inst_done. A fresh inst_valid then restarts at the lowest stage.

Source files
------------

// File: rtl/stage_sequencer_if.sv
// stage_sequencer_if: decoder handshake plus ALU/TX/RX datapath signals of the stage sequencer.
interface stage_sequencer_if #(
    parameter int NSTAGES  = 4,
    parameter int REG_BITS = 8,
    parameter int NSHIFT   = 2,
    parameter int REP_BITS = 4
);
    localparam int SW = $clog2(NSTAGES);
    localparam int CW = $clog2(2 * REG_BITS / NSHIFT);
    logic                inst_valid;
    logic                inst_done;
    logic [NSTAGES-1:0]  stage_mask;
    logic [NSTAGES-1:0]  stage_send;
    logic [NSTAGES-1:0]  stage_wait_rx;
    logic [NSTAGES-1:0]  stage_wide;
    logic [SW-1:0]       repeat_stage;
    logic [REP_BITS-1:0] repeat_count;
    logic                use_cc;
    logic [3:0]          cc;
    logic [3:0]          flags;
    logic                tx_command_valid;
    logic                tx_command_started;
    logic                rx_data_valid;
    logic                busy;
    logic [SW-1:0]       stage;
    logic [REP_BITS-1:0] rep_index;
    logic [CW-1:0]       counter;
    logic                advance;
    logic                op_last;
    modport master (
        output inst_valid, stage_mask, stage_send, stage_wait_rx, stage_wide, repeat_stage,
               repeat_count, use_cc, cc, flags, tx_command_started, rx_data_valid,
        input  inst_done, tx_command_valid, busy, stage, rep_index, counter, advance, op_last
    );
    modport slave (
        input  inst_valid, stage_mask, stage_send, stage_wait_rx, stage_wide, repeat_stage,
               repeat_count, use_cc, cc, flags, tx_command_started, rx_data_valid,
        output inst_done, tx_command_valid, busy, stage, rep_index, counter, advance, op_last
    );
endinterface

// File: rtl/stage_sequencer.sv
// stage_sequencer: walks an instruction through its enabled stages, counting bit-serial ALU cycles.
module stage_sequencer #(
    parameter int NSTAGES  = 4,
    parameter int REG_BITS = 8,
    parameter int NSHIFT   = 2,
    parameter int REP_BITS = 4
) (
    input logic clk,
    input logic reset,
    stage_sequencer_if.slave io
);
    localparam int SW = $clog2(NSTAGES);
    localparam int CW = $clog2(2 * REG_BITS / NSHIFT);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       stage_q, stage_d;
    logic [REP_BITS-1:0] rep_q, rep_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                sent_q, sent_d;
    logic [NSTAGES-1:0]  em;
    logic [SW-1:0]       first_s, next_s;
    logic                has_next;
    logic                cv, cond, cc_ok;
    logic [CW-1:0]       last_cnt;

    assign cv    = io.cc[0] ? io.flags[2] : io.flags[3];
    assign cond  = !io.cc[2] ? (io.cc[1] ? io.flags[1] : io.flags[0]) : (io.cc[1] ? cv && !io.flags[0] : cv);
    assign cc_ok = (io.cc[2:0] == 3'b000) ? 1'b1 : cond ^ io.cc[3];

    assign last_cnt = CW'((io.stage_wide[stage_q] ? 2 * REG_BITS : REG_BITS) / NSHIFT - 1);

    assign io.busy      = (state_q == RUN);
    assign io.stage     = stage_q;
    assign io.rep_index = rep_q;
    assign io.counter   = cnt_q;

    // A zero repeat count removes the repeatable stage from the walk entirely.
    always_comb begin
        em = io.stage_mask;
        if (io.repeat_count == '0) em[io.repeat_stage] = 1'b0;
        first_s  = '0;
        next_s   = '0;
        has_next = 1'b0;
        for (int i = NSTAGES - 1; i >= 0; i--) begin
            if (em[i]) first_s = SW'(i);
            if (em[i] && SW'(i) > stage_q) begin
                next_s   = SW'(i);
                has_next = 1'b1;
            end
        end
    end

    always_comb begin
        state_d             = state_q;
        stage_d             = stage_q;
        rep_d               = rep_q;
        cnt_d               = cnt_q;
        sent_d              = sent_q;
        io.inst_done        = 1'b0;
        io.tx_command_valid = 1'b0;
        io.advance          = 1'b0;
        io.op_last          = 1'b0;
        if (state_q == IDLE) begin
            if (io.inst_valid) begin
                if ((io.use_cc && !cc_ok) || em == '0) begin
                    io.inst_done = 1'b1;
                end else begin
                    state_d = RUN;
                    stage_d = first_s;
                    rep_d   = '0;
                    cnt_d   = '0;
                    sent_d  = 1'b0;
                end
            end
        end else begin
            io.tx_command_valid = io.stage_send[stage_q] && !sent_q;
            io.advance          = !io.tx_command_valid && !(io.stage_wait_rx[stage_q] && !io.rx_data_valid);
            io.op_last          = io.advance && cnt_q == last_cnt;
            if (io.tx_command_valid && io.tx_command_started) sent_d = 1'b1;
            if (io.advance) cnt_d = cnt_q + 1'b1;
            // Repetitions keep cmd_sent so the stage's command goes out only once.
            if (io.op_last) begin
                cnt_d = '0;
                if (stage_q == io.repeat_stage && {1'b0, rep_q} + 1'b1 < {1'b0, io.repeat_count}) begin
                    rep_d = rep_q + 1'b1;
                end else if (has_next) begin
                    stage_d = next_s;
                    rep_d   = '0;
                    sent_d  = 1'b0;
                end else begin
                    io.inst_done = 1'b1;
                    state_d      = IDLE;
                    stage_d      = '0;
                    rep_d        = '0;
                    sent_d       = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            stage_q <= '0;
            rep_q   <= '0;
            cnt_q   <= '0;
            sent_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            rep_q   <= rep_d;
            cnt_q   <= cnt_d;
            sent_q  <= sent_d;
        end
    end
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed and random instructions checked against an op-queue reference model.
module tb_stage_sequencer;
    localparam int NSTAGES  = 4;
    localparam int REG_BITS = 8;
    localparam int NSHIFT   = 2;
    localparam int REP_BITS = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    stage_sequencer_if #(.NSTAGES(NSTAGES), .REG_BITS(REG_BITS), .NSHIFT(NSHIFT), .REP_BITS(REP_BITS)) io();
    stage_sequencer #(.NSTAGES(NSTAGES), .REG_BITS(REG_BITS), .NSHIFT(NSHIFT), .REP_BITS(REP_BITS))
        dut (.clk(clk), .reset(reset), .io(io));

    int checks = 0;
    int errors = 0;

    // Reference model: the instruction expands into a queue of (stage, repetition) ops.
    bit m_busy = 0;
    bit m_sent = 0;
    int m_pos  = 0;
    int q_stage[$];
    int q_rep[$];

    int o_done, o_busy, o_txv, o_adv, o_last, o_stage, o_rep, o_cnt;
    int n_adv, n_start, n_txv, n_busy, max_rep;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cc_ok_f(input logic [3:0] cc, input logic [3:0] f);
        bit r;
        case (cc[2:0])
            3'd0: return 1'b1;
            3'd1: r = f[0];
            3'd2, 3'd3: r = f[1];
            3'd4: r = f[3];
            3'd5: r = f[2];
            3'd6: r = f[3] && !f[0];
            default: r = f[2] && !f[0];
        endcase
        return r ^ cc[3];
    endfunction

    // Called at a falling edge with this cycle's inputs applied; returns at the next falling edge.
    task automatic tick();
        bit e_done, e_txv, e_adv, e_last;
        int e_stage, e_rep, e_cnt, s, len, n;
        logic [NSTAGES-1:0] em;
        #1;
        o_done = io.inst_done; o_busy = io.busy; o_txv = io.tx_command_valid; o_adv = io.advance;
        o_last = io.op_last; o_stage = io.stage; o_rep = io.rep_index; o_cnt = io.counter;
        n_adv += o_adv; n_txv += o_txv; n_busy += o_busy;
        n_start += (o_txv != 0 && io.tx_command_started) ? 1 : 0;
        if (o_rep > max_rep) max_rep = o_rep;
        if (reset) begin
            m_busy = 0; m_sent = 0; m_pos = 0; q_stage.delete(); q_rep.delete();
        end else begin
            e_done = 0; e_txv = 0; e_adv = 0; e_last = 0; e_stage = 0; e_rep = 0; e_cnt = 0; s = 0;
            em = io.stage_mask;
            if (io.repeat_count == 0) em[io.repeat_stage] = 1'b0;
            if (m_busy) begin
                s = q_stage[0];
                len = (io.stage_wide[s] ? 2 * REG_BITS : REG_BITS) / NSHIFT;
                e_txv = io.stage_send[s] && !m_sent;
                e_adv = !e_txv && (!io.stage_wait_rx[s] || io.rx_data_valid);
                e_last = e_adv && m_pos == len - 1;
                e_done = e_last && q_stage.size() == 1;
                e_stage = s; e_rep = q_rep[0]; e_cnt = m_pos;
            end else if (io.inst_valid) begin
                e_done = (io.use_cc && !cc_ok_f(io.cc, io.flags)) || em == 0;
            end
            chk("busy", o_busy, int'(m_busy));
            chk("inst_done", o_done, int'(e_done));
            chk("tx_command_valid", o_txv, int'(e_txv));
            chk("advance", o_adv, int'(e_adv));
            chk("op_last", o_last, int'(e_last));
            if (m_busy) begin
                chk("stage", o_stage, e_stage);
                chk("rep_index", o_rep, e_rep);
                chk("counter", o_cnt, e_cnt);
                if (e_txv && io.tx_command_started) m_sent = 1;
                if (e_adv) m_pos++;
                if (e_last) begin
                    m_pos = 0;
                    void'(q_stage.pop_front());
                    void'(q_rep.pop_front());
                    if (q_stage.size() == 0) m_busy = 0;
                    else if (q_stage[0] != s) m_sent = 0;
                end
            end else if (io.inst_valid && !e_done) begin
                for (int i = 0; i < NSTAGES; i++) begin
                    n = (i == int'(io.repeat_stage)) ? int'(io.repeat_count) : 1;
                    if (em[i]) for (int r = 0; r < n; r++) begin q_stage.push_back(i); q_rep.push_back(r); end
                end
                m_busy = 1; m_pos = 0; m_sent = 0;
            end
        end
        @(negedge clk);
    endtask

    // rxm: 0 = rx always valid, 1 = valid on odd cycles, 2 = random; start_at < 0 = random accept.
    task automatic run_inst(input int rxm, input int start_at, input int max_c, input bit rflags, output int cyc);
        cyc = 0; n_adv = 0; n_start = 0; n_txv = 0; n_busy = 0; max_rep = 0; o_done = 0;
        io.inst_valid = 1'b1;
        while (!o_done && cyc < max_c) begin
            cyc++;
            io.rx_data_valid = rxm == 0 ? 1'b1 : rxm == 1 ? cyc[0] : 1'($urandom);
            io.tx_command_started = start_at < 0 ? 1'($urandom) : (cyc == start_at);
            if (rflags && cyc > 1) io.flags = 4'($urandom);
            tick();
        end
        if (!o_done) chk("done_timeout", o_done, 1);
    endtask

    task automatic set_inst(input logic [3:0] mask, input logic [3:0] send, input logic [3:0] wt,
                            input logic [3:0] wide, input int rs, input int rc, input bit ucc,
                            input logic [3:0] cc, input logic [3:0] fl);
        io.stage_mask = mask; io.stage_send = send; io.stage_wait_rx = wt; io.stage_wide = wide;
        io.repeat_stage = 2'(rs); io.repeat_count = 4'(rc); io.use_cc = ucc; io.cc = cc; io.flags = fl;
    endtask

    initial begin
        int cyc;
        bit found;
        io.inst_valid = 0; io.tx_command_started = 0; io.rx_data_valid = 0;
        set_inst(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 4'b0000, 4'b0000);
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("reset_busy", o_busy, 0); chk("reset_done", o_done, 0); chk("reset_adv", o_adv, 0);
        chk("reset_txv", o_txv, 0); chk("reset_stage", o_stage, 0); chk("reset_cnt", o_cnt, 0);

        set_inst(4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 4'b0000, 4'b0000);
        run_inst(0, -1, 50, 0, cyc);
        chk("t1_cycles", cyc, 5); chk("t1_adv", n_adv, 4); chk("t1_last", o_last, 1);
        io.inst_valid = 0; tick();

        set_inst(4'b0011, 4'b0001, 4'b0010, 4'b0001, 3, 1, 0, 4'b0000, 4'b0000);
        run_inst(1, 3, 80, 0, cyc);
        chk("t2_cycles", cyc, 19); chk("t2_adv", n_adv, 12); chk("t2_starts", n_start, 1); chk("t2_txv", n_txv, 2);
        io.inst_valid = 0; tick();

        set_inst(4'b0001, 4'b0001, 4'b0000, 4'b0000, 0, 1, 1, 4'b0001, 4'b0000);
        run_inst(0, 2, 50, 0, cyc);
        chk("t3_skip_cycles", cyc, 1); chk("t3_busy", n_busy, 0); chk("t3_txv", n_txv, 0);
        set_inst(4'b0001, 4'b0001, 4'b0000, 4'b0000, 0, 1, 1, 4'b1001, 4'b0000);
        run_inst(0, 2, 50, 0, cyc);
        chk("t3_exec_cycles", cyc, 6);

        set_inst(4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1, 4'b0110, 4'b1001);
        run_inst(0, -1, 50, 0, cyc);
        chk("t4_skip_cycles", cyc, 1);
        set_inst(4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1, 4'b0110, 4'b1000);
        run_inst(0, -1, 50, 1, cyc);
        chk("t4_exec_cycles", cyc, 5);

        set_inst(4'b0110, 4'b0100, 4'b0000, 4'b0000, 2, 3, 0, 4'b0000, 4'b0000);
        run_inst(0, -1, 200, 0, cyc);
        chk("t5_adv", n_adv, 16); chk("t5_starts", n_start, 1); chk("t5_max_rep", max_rep, 2);
        set_inst(4'b0110, 4'b0100, 4'b0000, 4'b0000, 2, 0, 0, 4'b0000, 4'b0000);
        run_inst(0, -1, 200, 0, cyc);
        chk("t5_zero_cycles", cyc, 5); chk("t5_zero_adv", n_adv, 4); chk("t5_zero_txv", n_txv, 0);
        io.inst_valid = 0; tick();

        set_inst(4'b0011, 4'b0000, 4'b0000, 4'b0010, 0, 1, 0, 4'b0000, 4'b0000);
        io.inst_valid = 1;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            found = o_busy != 0 && o_stage == 1 && o_cnt == 1;
        end
        chk("t6_reach", int'(found), 1);
        reset = 1'b1; tick();
        chk("t6_pre_reset_cnt", o_cnt, 2);
        reset = 1'b0; io.inst_valid = 0; tick();
        chk("t6_busy", o_busy, 0); chk("t6_done", o_done, 0); chk("t6_adv", o_adv, 0); chk("t6_txv", o_txv, 0);
        chk("t6_last", o_last, 0); chk("t6_stage", o_stage, 0); chk("t6_cnt", o_cnt, 0); chk("t6_rep", o_rep, 0);
        io.inst_valid = 1; tick();
        chk("t6_entry_busy", o_busy, 0);
        run_inst(0, -1, 50, 0, cyc);
        chk("t6_restart_cycles", cyc, 12);

        for (int t = 0; t < 250; t++) begin
            set_inst(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), 1'($urandom), 4'($urandom), 4'($urandom));
            run_inst(2, -1, 400, 1, cyc);
            if ($urandom_range(0, 2) == 0) begin io.inst_valid = 0; tick(); end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
